// File: rtl/f1_pkg.sv
// Shared types and helpers for the F1 start-light reaction timer.
package f1_pkg;

    // Widest light bar the helper below supports; narrower bars use the low bits.
    localparam int MAX_LIGHTS = 32;

    // All lights on, sliced down to the actual bar width by the user.
    localparam logic [MAX_LIGHTS-1:0] LIGHTS_ALL = '1;

    typedef enum logic [2:0] {
        IDLE,
        FILLING,
        ARMED,
        TIMING,
        DONE,
        FAULT
    } state_t;

    // One thermometer step: shift up and light one more lamp at the bottom.
    function automatic logic [MAX_LIGHTS-1:0] therm_next(input logic [MAX_LIGHTS-1:0] x);
        return {x[MAX_LIGHTS-2:0], 1'b1};
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for the already-synchronised button level.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Remember last cycle's level to spot the low-to-high transition.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/f1_reaction_timer.sv
// Measures driver reaction from lights-out to button press and flags
// jump starts, timeouts and malformed light sequences.
module f1_reaction_timer
    import f1_pkg::*;
#(
    parameter int N_LIGHTS = 8,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_LIGHTS-1:0] lights,
    input  logic                tick,
    input  logic                btn,
    output logic [CNT_W-1:0]    react_time,
    output logic                result_valid,
    output logic                jump_start,
    output logic                timeout,
    output logic                seq_err,
    output logic                busy
);

    localparam logic [N_LIGHTS-1:0] LIGHTS_FULL = LIGHTS_ALL[N_LIGHTS-1:0];
    localparam logic [N_LIGHTS-1:0] LIGHTS_ONE  = N_LIGHTS'(1);
    localparam logic [N_LIGHTS-1:0] LIGHTS_OFF  = '0;
    localparam logic [CNT_W-1:0]    CNT_MAX     = '1;

    state_t              state, state_d;
    logic [N_LIGHTS-1:0] lights_q;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [CNT_W-1:0]    react_d;
    logic                jump_d, timeout_d, valid_d;
    logic                press;
    logic [N_LIGHTS-1:0] step_next;
    logic                step_ok;

    rise_detect u_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn),
        .rise  (press)
    );

    // A legal filling step either holds the previous pattern or adds one lamp.
    assign step_next = N_LIGHTS'(therm_next(MAX_LIGHTS'(lights_q)));
    assign step_ok   = (lights == lights_q) || (lights == step_next);

    // Next-state, counter and result computation for the measurement FSM.
    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        react_d   = react_time;
        jump_d    = jump_start;
        timeout_d = timeout;

        case (state)
            IDLE: begin
                if (lights == LIGHTS_ONE) begin
                    state_d   = FILLING;
                    jump_d    = 1'b0;
                    timeout_d = 1'b0;
                end else if (lights != LIGHTS_OFF) begin
                    state_d = FAULT;
                end
            end
            FILLING: begin
                if (press) begin
                    state_d = DONE;
                    jump_d  = 1'b1;
                    react_d = '0;
                end else if (!step_ok) begin
                    state_d = FAULT;
                end else if (lights == LIGHTS_FULL) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                // A press on the very cycle the lights go out is a legal zero-tick reaction.
                if (press) begin
                    state_d = DONE;
                    react_d = '0;
                    jump_d  = (lights != LIGHTS_OFF);
                end else if (lights == LIGHTS_OFF) begin
                    state_d = TIMING;
                    cnt_d   = '0;
                end else if (lights != LIGHTS_FULL) begin
                    state_d = FAULT;
                end
            end
            TIMING: begin
                if (press) begin
                    state_d = DONE;
                    react_d = cnt;
                end else if (lights != LIGHTS_OFF) begin
                    state_d = FAULT;
                end else if (tick) begin
                    if (cnt == CNT_MAX) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                        react_d   = CNT_MAX;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (lights == LIGHTS_ONE) begin
                    state_d   = FILLING;
                    jump_d    = 1'b0;
                    timeout_d = 1'b0;
                end else if (lights != LIGHTS_OFF) begin
                    state_d = FAULT;
                end
            end
            FAULT: begin
                if (lights == LIGHTS_OFF) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result strobe fires only on entry into DONE, not while it is held.
    assign valid_d = (state_d == DONE) && (state != DONE);

    // State, counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lights_q     <= '0;
            cnt          <= '0;
            react_time   <= '0;
            jump_start   <= 1'b0;
            timeout      <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_d;
            lights_q     <= lights;
            cnt          <= cnt_d;
            react_time   <= react_d;
            jump_start   <= jump_d;
            timeout      <= timeout_d;
            result_valid <= valid_d;
        end
    end

    assign seq_err = (state == FAULT);
    assign busy    = (state == FILLING) || (state == ARMED) || (state == TIMING);

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Directed bench for f1_reaction_timer: main instance with CNT_W=16 and a
// narrow CNT_W=4 instance for the saturation scenario.
module tb_f1_reaction_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [7:0]  lights = 8'h00;
    logic        tick = 1'b1;
    logic        btn = 1'b0;
    logic [15:0] react_time;
    logic        result_valid, jump_start, timeout, seq_err, busy;

    logic [7:0]  lights4 = 8'h00;
    logic        tick4 = 1'b1;
    logic        btn4 = 1'b0;
    logic [3:0]  react_time4;
    logic        result_valid4, jump_start4, timeout4, seq_err4, busy4;

    int n_vec = 0;
    int n_err = 0;

    // Observed bundles: {react_time, result_valid, jump_start, timeout, seq_err, busy}
    logic [20:0] obs;
    logic [8:0]  obs4;
    assign obs  = {react_time, result_valid, jump_start, timeout, seq_err, busy};
    assign obs4 = {react_time4, result_valid4, jump_start4, timeout4, seq_err4, busy4};

    f1_reaction_timer #(.N_LIGHTS(8), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lights       (lights),
        .tick         (tick),
        .btn          (btn),
        .react_time   (react_time),
        .result_valid (result_valid),
        .jump_start   (jump_start),
        .timeout      (timeout),
        .seq_err      (seq_err),
        .busy         (busy)
    );

    f1_reaction_timer #(.N_LIGHTS(8), .CNT_W(4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .lights       (lights4),
        .tick         (tick4),
        .btn          (btn4),
        .react_time   (react_time4),
        .result_valid (result_valid4),
        .jump_start   (jump_start4),
        .timeout      (timeout4),
        .seq_err      (seq_err4),
        .busy         (busy4)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drive 01,03,...,FF on the main instance, each held for 'hold' cycles.
    task automatic fill(input int hold);
        for (int i = 1; i <= 8; i++) begin
            lights = 8'((1 << i) - 1);
            repeat (hold) step();
        end
    endtask

    task automatic test_reset;
        logic [20:0] exp;
        logic [8:0]  exp4;
        rst_n = 1'b0;
        step();
        step();
        exp = 21'd0;
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL reset_outputs: got %h want %h", obs, exp); end
        exp4 = 9'd0;
        n_vec++; if (obs4 !== exp4) begin n_err++; $display("FAIL reset_outputs4: got %h want %h", obs4, exp4); end
        rst_n = 1'b1;
        step();
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL idle_after_reset: got %h want %h", obs, exp); end
    endtask

    task automatic test_normal;
        logic [20:0] exp;
        fill(2);
        exp = {16'd0, 5'b00001};
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL normal_armed: got %h want %h", obs, exp); end
        repeat (3) step();
        lights = 8'h00;
        step();
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL normal_timing: got %h want %h", obs, exp); end
        repeat (5) step();
        btn = 1'b1;
        step();
        exp = {16'd5, 5'b10000};
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL normal_result: got %h want %h", obs, exp); end
        btn = 1'b0;
        step();
        exp = {16'd5, 5'b00000};
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL normal_held: got %h want %h", obs, exp); end
    endtask

    task automatic test_simultaneous;
        logic [20:0] exp;
        lights = 8'h01;
        step();
        exp = {16'd5, 5'b00001};
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL simul_refill: got %h want %h", obs, exp); end
        fill(1);
        lights = 8'h00;
        btn    = 1'b1;
        step();
        exp = {16'd0, 5'b10000};
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL simul_result: got %h want %h", obs, exp); end
        btn = 1'b0;
        step();
        exp = {16'd0, 5'b00000};
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL simul_held: got %h want %h", obs, exp); end
    endtask

    task automatic test_jump_start;
        logic [20:0] exp;
        lights = 8'h01; step();
        lights = 8'h03; step();
        lights = 8'h07; step();
        btn = 1'b1;
        step();
        exp = {16'd0, 5'b11000};
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL jump_result: got %h want %h", obs, exp); end
        lights = 8'h00;
        btn    = 1'b0;
        step();
        exp = {16'd0, 5'b01000};
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL jump_held: got %h want %h", obs, exp); end
    endtask

    task automatic test_tick_gate;
        logic [20:0] exp;
        lights = 8'h01;
        step();
        exp = {16'd0, 5'b00001};
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL tick_flags_cleared: got %h want %h", obs, exp); end
        fill(1);
        lights = 8'h00;
        step();
        tick = 1'b0;
        repeat (3) step();
        tick = 1'b1;
        repeat (2) step();
        btn = 1'b1;
        step();
        exp = {16'd2, 5'b10000};
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL tick_gated_count: got %h want %h", obs, exp); end
        btn = 1'b0;
        step();
    endtask

    task automatic test_bad_sequence;
        logic [20:0] exp;
        lights = 8'h01;
        step();
        exp = {16'd2, 5'b00001};
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL badseq_filling: got %h want %h", obs, exp); end
        lights = 8'h05;
        step();
        exp = {16'd2, 5'b00010};
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL badseq_fault: got %h want %h", obs, exp); end
        lights = 8'h01;
        btn    = 1'b1;
        step();
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL badseq_fault_held: got %h want %h", obs, exp); end
        btn    = 1'b0;
        lights = 8'h00;
        step();
        exp = {16'd2, 5'b00000};
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL badseq_to_idle: got %h want %h", obs, exp); end
        lights = 8'h03;
        step();
        exp = {16'd2, 5'b00010};
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL badseq_idle_fault: got %h want %h", obs, exp); end
        lights = 8'h00;
        step();
        exp = {16'd2, 5'b00000};
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL badseq_idle_recover: got %h want %h", obs, exp); end
    endtask

    task automatic test_timeout;
        logic [8:0] exp4;
        for (int i = 1; i <= 8; i++) begin
            lights4 = 8'((1 << i) - 1);
            step();
        end
        lights4 = 8'h00;
        step();
        repeat (15) step();
        exp4 = {4'd0, 5'b00001};
        n_vec++; if (obs4 !== exp4) begin n_err++; $display("FAIL timeout_at_max: got %h want %h", obs4, exp4); end
        step();
        exp4 = {4'd15, 5'b10100};
        n_vec++; if (obs4 !== exp4) begin n_err++; $display("FAIL timeout_result: got %h want %h", obs4, exp4); end
        step();
        exp4 = {4'd15, 5'b00100};
        n_vec++; if (obs4 !== exp4) begin n_err++; $display("FAIL timeout_held: got %h want %h", obs4, exp4); end
    endtask

    task automatic test_reset_mid_run;
        logic [20:0] exp;
        logic [8:0]  exp4;
        fill(1);
        lights = 8'h00;
        step();
        repeat (2) step();
        exp = {16'd2, 5'b00001};
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL rst_pre_timing: got %h want %h", obs, exp); end
        rst_n = 1'b0;
        btn   = 1'b1;
        #1;
        exp = 21'd0;
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL rst_async_clear: got %h want %h", obs, exp); end
        exp4 = 9'd0;
        n_vec++; if (obs4 !== exp4) begin n_err++; $display("FAIL rst_async_clear4: got %h want %h", obs4, exp4); end
        step();
        rst_n = 1'b1;
        repeat (2) step();
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL rst_idle_btn_high: got %h want %h", obs, exp); end
        fill(1);
        lights = 8'h00;
        step();
        repeat (4) step();
        exp = {16'd0, 5'b00001};
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL rst_no_press_held_btn: got %h want %h", obs, exp); end
        btn = 1'b0;
        step();
        btn = 1'b1;
        step();
        exp = {16'd5, 5'b10000};
        n_vec++; if (obs !== exp) begin n_err++; $display("FAIL rst_press_after_release: got %h want %h", obs, exp); end
        btn = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_simultaneous();
        test_jump_start();
        test_tick_gate();
        test_bad_sequence();
        test_timeout();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
